multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 147 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32 subset control FSM (IF/ID/EX/MEM/WB/TRAP)
// Ports: clk, rst (async, active-high); inst, imem_ack, mem_ready, br_taken in;
//   imem_req, ir_we, pc_we, reg_we, mem_we, mem_re, npc_sel strobes; alu_op,
//   alu_asel, alu_bsel, wb_sel, immgen_op decode; state, sticky fault, instret.
// Macro MEM_HANDSHAKE_EN: MEM waits on mem_ready with a MEM_TIMEOUT bus-fault
//   watchdog; when undefined MEM is a single cycle and mem_ready is ignored.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        imem_ack,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        mem_we,
    output logic        mem_re,
    output logic [3:0]  alu_op,
    output logic [1:0]  alu_asel,
    output logic [1:0]  alu_bsel,
    output logic [1:0]  wb_sel,
    output logic        npc_sel,
    output logic [2:0]  immgen_op,
    output logic [2:0]  state,
    output logic        fault,
    output logic [31:0] instret
);
    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7
    } state_t;

    state_t st, nx;
    logic [2:0] f3;
    logic is_r, is_i, is_ld, is_st, is_br, is_jal, legal, dec_on, alt;
    logic mem_done, mem_tout;
    logic [3:0] op_raw;
    logic unused_bits;

    assign state = st;
    assign f3 = inst[14:12];
    assign is_r = inst[6:0] == 7'b0110011;
    assign is_i = inst[6:0] == 7'b0010011;
    assign is_ld = inst[6:0] == 7'b0000011;
    assign is_st = inst[6:0] == 7'b0100011;
    assign is_br = inst[6:0] == 7'b1100011;
    assign is_jal = inst[6:0] == 7'b1101111;
    assign legal = is_r | is_i | is_ld | is_st | is_br | is_jal;
    assign dec_on = legal && (st == S_ID || st == S_EX || st == S_MEM || st == S_WB);
    // inst[30] selects sub/sra; immediate ALU ops only honour it for shifts
    assign alt = inst[30] & (is_r | f3 == 3'b101);
    assign unused_bits = ^{inst[31], inst[29:15], inst[11:7]};

    always_comb begin
        case (f3)
            3'b000:  op_raw = {3'b000, alt};
            3'b001:  op_raw = 4'b0111;
            3'b010:  op_raw = 4'b0101;
            3'b011:  op_raw = 4'b0110;
            3'b100:  op_raw = 4'b0100;
            3'b101:  op_raw = {3'b100, alt};
            3'b110:  op_raw = 4'b0011;
            default: op_raw = 4'b0010;
        endcase
    end

    assign alu_op = (dec_on && (is_r || is_i)) ? op_raw : 4'b0000;
    assign alu_asel = !dec_on ? 2'b00 : (is_jal || is_br) ? 2'b10 : 2'b01;
    assign alu_bsel = !dec_on ? 2'b00 : is_r ? 2'b01 : 2'b10;
    assign wb_sel = !dec_on ? 2'b00 : is_ld ? 2'b10 : is_jal ? 2'b11 : 2'b01;
    assign immgen_op = !dec_on ? 3'b000 : is_r ? 3'b000 : is_st ? 3'b010 :
                       is_br ? 3'b011 : is_jal ? 3'b100 : 3'b001;

`ifdef MEM_HANDSHAKE_EN
    logic [3:0] wcnt;
    assign mem_done = mem_ready;
    // the cycle that would make the wait count reach MEM_TIMEOUT faults instead
    assign mem_tout = !mem_ready && wcnt == 4'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wcnt <= 4'd0;
        else
            wcnt <= (st == S_MEM && !mem_ready) ? wcnt + 4'd1 : 4'd0;
    end
`else
    logic unused_ready;
    assign unused_ready = mem_ready;
    assign mem_done = 1'b1;
    assign mem_tout = 1'b0;
`endif

    always_comb begin
        nx = st;
        imem_req = 1'b0;
        ir_we = 1'b0;
        pc_we = 1'b0;
        reg_we = 1'b0;
        mem_we = 1'b0;
        mem_re = 1'b0;
        npc_sel = 1'b0;
        case (st)
            S_IF: begin
                // reset parks the FSM in IF, so only the fetch strobes need masking
                imem_req = !rst;
                ir_we = imem_ack & !rst;
                nx = imem_ack ? S_ID : S_IF;
            end
            S_ID: nx = legal ? S_EX : S_TRAP;
            S_EX: begin
                pc_we = is_br;
                npc_sel = is_br & br_taken;
                nx = (is_ld || is_st) ? S_MEM : is_br ? S_IF : S_WB;
            end
            S_MEM: begin
                mem_re = is_ld;
                mem_we = is_st;
                pc_we = is_st & mem_done;
                nx = mem_done ? (is_ld ? S_WB : S_IF) : mem_tout ? S_TRAP : S_MEM;
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we = 1'b1;
                npc_sel = is_jal;
                nx = S_IF;
            end
            S_TRAP: nx = S_TRAP;
            default: nx = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= S_IF;
            fault <= 1'b0;
            instret <= 32'd0;
        end else begin
            st <= nx;
            fault <= fault | (nx == S_TRAP);
            if (pc_we)
                instret <= instret + 32'd1;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven directed bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] inst = 32'd0;
    logic imem_ack = 1'b0, mem_ready = 1'b0, br_taken = 1'b0;
    logic imem_req, ir_we, pc_we, reg_we, mem_we, mem_re, npc_sel, fault;
    logic [3:0] alu_op;
    logic [1:0] alu_asel, alu_bsel, wb_sel;
    logic [2:0] immgen_op, state;
    logic [31:0] instret;
    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .inst(inst), .imem_ack(imem_ack), .mem_ready(mem_ready),
        .br_taken(br_taken), .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
        .reg_we(reg_we), .mem_we(mem_we), .mem_re(mem_re), .alu_op(alu_op),
        .alu_asel(alu_asel), .alu_bsel(alu_bsel), .wb_sel(wb_sel), .npc_sel(npc_sel),
        .immgen_op(immgen_op), .state(state), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_ADD = 32'h002081B3, I_SUB = 32'h402081B3, I_SRA = 32'h4020D1B3;
    localparam logic [31:0] I_BEQ = 32'h00208463, I_JAL = 32'h008000EF, I_SRAI = 32'h4010D093;
    localparam logic [31:0] I_ADDI = 32'h40008093, I_LW = 32'h0000A183, I_SW = 32'h0020A023;
    localparam logic [31:0] I_ILL = 32'h0000007F;
    // decode fields {alu_op, alu_asel, alu_bsel, wb_sel, immgen_op}
    localparam logic [12:0] D0 = 13'd0;
    localparam logic [12:0] D_ADD = {4'b0000, 2'b01, 2'b01, 2'b01, 3'b000};
    localparam logic [12:0] D_SUB = {4'b0001, 2'b01, 2'b01, 2'b01, 3'b000};
    localparam logic [12:0] D_SRA = {4'b1001, 2'b01, 2'b01, 2'b01, 3'b000};
    localparam logic [12:0] D_BR = {4'b0000, 2'b10, 2'b10, 2'b01, 3'b011};
    localparam logic [12:0] D_JAL = {4'b0000, 2'b10, 2'b10, 2'b11, 3'b100};
    localparam logic [12:0] D_SRAI = {4'b1001, 2'b01, 2'b10, 2'b01, 3'b001};
    localparam logic [12:0] D_ADDI = {4'b0000, 2'b01, 2'b10, 2'b01, 3'b001};
    localparam logic [12:0] D_LD = {4'b0000, 2'b01, 2'b10, 2'b10, 3'b001};
    localparam logic [12:0] D_ST = {4'b0000, 2'b01, 2'b10, 2'b01, 3'b010};
    // strobes {imem_req, ir_we, pc_we, reg_we, mem_we, mem_re, npc_sel}
    localparam logic [6:0] K_F1 = 7'b1100000, K_F0 = 7'b1000000, K_N = 7'b0000000;
    localparam logic [6:0] K_WB = 7'b0011000, K_WBJ = 7'b0011001, K_BT = 7'b0010001;
    localparam logic [6:0] K_BN = 7'b0010000, K_RD = 7'b0000010, K_WRD = 7'b0010100;

    typedef struct {
        logic [31:0] inst;
        logic ack, rdy, br;
        logic [55:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [55:0] snap();
        return {state, imem_req, ir_we, pc_we, reg_we, mem_we, mem_re, npc_sel, fault,
                alu_op, alu_asel, alu_bsel, wb_sel, immgen_op, instret};
    endfunction

    task automatic row(input logic [31:0] i, input logic a, rd, b, input logic [2:0] s,
                       input logic [6:0] sb, input logic [12:0] d, input logic [31:0] n);
        vec_t v;
        v.inst = i; v.ack = a; v.rdy = rd; v.br = b;
        v.exp = {s, sb, 1'b0, d, n};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step(input logic [31:0] i, input logic a, rd, b);
        @(negedge clk);
        rst = 1'b0; inst = i; imem_ack = a; mem_ready = rd; br_taken = b;
        #1;
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1; imem_ack = 1'b1; mem_ready = 1'b1; br_taken = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk(name, 64'(snap()), 64'd0);
    endtask

    initial begin
        int cyc, memseen, rdcnt, memc;
        logic [1:0] wbs;
        logic done;
        row(I_ADD, 1, 0, 0, 3'd0, K_F1, D0, 0);
        row(I_ADD, 0, 0, 0, 3'd1, K_N, D_ADD, 0);
        row(I_ADD, 0, 0, 0, 3'd2, K_N, D_ADD, 0);
        row(I_ADD, 0, 0, 0, 3'd4, K_WB, D_ADD, 0);
        row(I_SUB, 0, 0, 0, 3'd0, K_F0, D0, 1);
        row(I_SUB, 1, 0, 0, 3'd0, K_F1, D0, 1);
        row(I_SUB, 0, 0, 0, 3'd1, K_N, D_SUB, 1);
        row(I_SUB, 0, 0, 0, 3'd2, K_N, D_SUB, 1);
        row(I_SUB, 0, 0, 0, 3'd4, K_WB, D_SUB, 1);
        row(I_SRA, 1, 0, 0, 3'd0, K_F1, D0, 2);
        row(I_SRA, 0, 0, 0, 3'd1, K_N, D_SRA, 2);
        row(I_SRA, 0, 0, 0, 3'd2, K_N, D_SRA, 2);
        row(I_SRA, 0, 0, 0, 3'd4, K_WB, D_SRA, 2);
        row(I_BEQ, 1, 0, 0, 3'd0, K_F1, D0, 3);
        row(I_BEQ, 0, 0, 0, 3'd1, K_N, D_BR, 3);
        row(I_BEQ, 0, 0, 1, 3'd2, K_BT, D_BR, 3);
        row(I_BEQ, 1, 0, 0, 3'd0, K_F1, D0, 4);
        row(I_BEQ, 0, 0, 0, 3'd1, K_N, D_BR, 4);
        row(I_BEQ, 0, 0, 0, 3'd2, K_BN, D_BR, 4);
        row(I_JAL, 1, 0, 0, 3'd0, K_F1, D0, 5);
        row(I_JAL, 0, 0, 0, 3'd1, K_N, D_JAL, 5);
        row(I_JAL, 0, 0, 0, 3'd2, K_N, D_JAL, 5);
        row(I_JAL, 0, 0, 0, 3'd4, K_WBJ, D_JAL, 5);
        row(I_SRAI, 1, 0, 0, 3'd0, K_F1, D0, 6);
        row(I_SRAI, 0, 0, 0, 3'd1, K_N, D_SRAI, 6);
        row(I_SRAI, 0, 0, 0, 3'd2, K_N, D_SRAI, 6);
        row(I_SRAI, 0, 0, 0, 3'd4, K_WB, D_SRAI, 6);
        row(I_ADDI, 1, 0, 0, 3'd0, K_F1, D0, 7);
        row(I_ADDI, 0, 0, 0, 3'd1, K_N, D_ADDI, 7);
        row(I_ADDI, 0, 0, 0, 3'd2, K_N, D_ADDI, 7);
        row(I_ADDI, 0, 0, 0, 3'd4, K_WB, D_ADDI, 7);
        row(I_LW, 1, 1, 0, 3'd0, K_F1, D0, 8);
        row(I_LW, 0, 1, 0, 3'd1, K_N, D_LD, 8);
        row(I_LW, 0, 1, 0, 3'd2, K_N, D_LD, 8);
        row(I_LW, 0, 1, 0, 3'd3, K_RD, D_LD, 8);
        row(I_LW, 0, 1, 0, 3'd4, K_WB, D_LD, 8);
        row(I_SW, 1, 1, 0, 3'd0, K_F1, D0, 9);
        row(I_SW, 0, 1, 0, 3'd1, K_N, D_ST, 9);
        row(I_SW, 0, 1, 0, 3'd2, K_N, D_ST, 9);
        row(I_SW, 0, 1, 0, 3'd3, K_WRD, D_ST, 9);
        row(I_LW, 0, 0, 0, 3'd0, K_F0, D0, 10);

        inst = I_ADD;
        do_reset("reset_state");
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].inst, tbl[i].ack, tbl[i].rdy, tbl[i].br);
            chk($sformatf("row%0d", i), 64'(snap()), 64'(tbl[i].exp));
        end

        // load with mem_ready arriving on the fourth MEM cycle
        cyc = 0; memseen = 0; rdcnt = 0; wbs = 2'b00; done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            step(I_LW, n == 0, memseen >= 3, 1'b0);
            if (n > 0 && state == 3'd0) done = 1'b1;
            else begin
                cyc++;
                if (mem_re) rdcnt++;
                if (state == 3'd3) memseen++;
                if (state == 3'd4) wbs = wb_sel;
            end
        end
        chk("lw_done", 64'(done), 64'd1);
`ifdef MEM_HANDSHAKE_EN
        chk("lw_cycles", 64'(cyc), 64'd8);
        chk("lw_mem_re", 64'(rdcnt), 64'd4);
`else
        chk("lw_cycles", 64'(cyc), 64'd5);
        chk("lw_mem_re", 64'(rdcnt), 64'd1);
`endif
        chk("lw_wb_sel", 64'(wbs), 64'd2);
        chk("lw_instret", 64'(instret), 64'd11);

        // reset landing inside a store's MEM cycle
        step(I_SW, 1, 0, 0);
        step(I_SW, 0, 0, 0);
        step(I_SW, 0, 0, 0);
        step(I_SW, 0, 0, 0);
        chk("midmem_pre", 64'({state, mem_we}), 64'({3'd3, 1'b1}));
        #2 rst = 1'b1;
        #1;
        chk("midmem_rst", 64'({state, mem_we, pc_we, instret}), 64'd0);
        do_reset("midmem_reset");

        // illegal opcode traps and stays trapped
        step(I_ILL, 1, 1, 1);
        step(I_ILL, 1, 1, 1);
        chk("ill_id", 64'(snap()), 64'({3'd1, K_N, 1'b0, D0, 32'd0}));
        for (int n = 0; n < 20; n++) begin
            step(I_ILL, 1, 1, 1);
            chk($sformatf("trap%0d", n), 64'(snap()), 64'({3'd7, K_N, 1'b1, D0, 32'd0}));
        end
        do_reset("trap_reset");

        // store with mem_ready held low
        step(I_SW, 1, 0, 0);
        step(I_SW, 0, 0, 0);
        step(I_SW, 0, 0, 0);
        memc = 0; done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            step(I_SW, 0, 0, 0);
            if (state == 3'd3 && mem_we) memc++;
            else done = 1'b1;
        end
        chk("sw_left_mem", 64'(done), 64'd1);
`ifdef MEM_HANDSHAKE_EN
        chk("sw_mem_cycles", 64'(memc), 64'd15);
        chk("sw_timeout", 64'({state, mem_we, fault, instret}), 64'({3'd7, 1'b0, 1'b1, 32'd0}));
`else
        chk("sw_mem_cycles", 64'(memc), 64'd1);
        chk("sw_single", 64'({state, mem_we, fault, instret}), 64'({3'd0, 1'b0, 1'b0, 32'd1}));
`endif
        do_reset("final_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
